// File: rtl/bus_sel_pkg.sv
// Shared datapath bus select encodings.
// Imported by the control unit (which issues select codes) and by the
// bus multiplexer (which decodes them). Holds the bus width, the number
// of bus sources and the named select code for every source.
package bus_sel_pkg;

  localparam int BUS_W       = 32;
  localparam int NUM_BUS_SRC = 12;
  localparam int SEL_CODE_W  = 8;

  // Source codes as driven on the select lines by the control unit.
  // Data RAM (code 0) is the narrow byte-wide source.
  // Instruction RAM (code 1) is the fallback source.
  typedef enum logic [SEL_CODE_W-1:0] {
    SEL_DRAM = 8'd0,
    SEL_IRAM = 8'd1,
    SEL_DI   = 8'd2,
    SEL_RI   = 8'd3,
    SEL_BI   = 8'd4,
    SEL_S    = 8'd5,
    SEL_C1   = 8'd6,
    SEL_C2   = 8'd7,
    SEL_AR   = 8'd8,
    SEL_AC   = 8'd9,
    SEL_PC   = 8'd10,
    SEL_IR   = 8'd11
  } bus_sel_e;

endpackage

// File: rtl/bus_src_select.sv
// Combinational source picker for the datapath bus.
// Range-checks a select code. An out-of-range code falls back to DEFAULT_SRC.
// The picker then returns that slot of the flattened source vector. The
// narrow slot is zero-extended from its low NARROW_W bits.
// Ports:
//   i_src_data  NUM_SRC*DATA_W  flattened sources, slot i at [i*DATA_W +: DATA_W]
//   i_sel       SEL_W           select code to decode
//   o_data      DATA_W          selected (and possibly zero-extended) source value
//   o_legal     1               i_sel is within 0..NUM_SRC-1
module bus_src_select
  import bus_sel_pkg::*;
#(
  parameter int DATA_W      = BUS_W,
  parameter int NUM_SRC     = NUM_BUS_SRC,
  parameter int SEL_W       = SEL_CODE_W,
  parameter int NARROW_SRC  = int'(SEL_DRAM),
  parameter int NARROW_W    = 8,
  parameter int DEFAULT_SRC = int'(SEL_IRAM)
) (
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_legal
);

  logic [DATA_W-1:0] w_slot [NUM_SRC];
  logic [SEL_W-1:0]  w_idx;

  // The compare is one bit wider than the select code, so that NUM_SRC == 2**SEL_W
  // still fits.
  assign o_legal = ({1'b0, i_sel} < (SEL_W+1)'(NUM_SRC));
  assign w_idx   = o_legal ? i_sel : SEL_W'(DEFAULT_SRC);

  // Split the flat vector into slots. The narrow slot keeps only its
  // low NARROW_W bits. Its upper bits are intentionally discarded.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    if (g == NARROW_SRC && NARROW_W < DATA_W) begin : g_narrow
      logic w_unused_narrow_hi;
      assign w_unused_narrow_hi = ^i_src_data[g*DATA_W+NARROW_W +: DATA_W-NARROW_W];
      assign w_slot[g] = {{(DATA_W-NARROW_W){1'b0}}, i_src_data[g*DATA_W +: NARROW_W]};
    end else begin : g_full
      assign w_slot[g] = i_src_data[g*DATA_W +: DATA_W];
    end
  end

  // Compare-and-pick mux. w_idx is always in range, so exactly one slot matches.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_idx == SEL_W'(i)) o_data = w_slot[i];
    end
  end

endmodule

// File: rtl/bus_src_mux_reg.sv
// Registered datapath bus multiplexer with a latched select.
// The control unit loads a select once. The bus then follows that
// source with one cycle of latency until the next load. Hold freezes the
// bus register but still accepts select loads. An illegal select falls back
// to DEFAULT_SRC and raises a sticky error flag.
// Ports:
//   i_clk         1               system clock, rising edge
//   i_rst_n       1               asynchronous active-low reset
//   i_src_data    NUM_SRC*DATA_W  flattened sources
//   i_sel         SEL_W           select code
//   i_sel_load    1               latch i_sel this cycle
//   i_hold        1               freeze the bus register
//   i_err_clr     1               clear o_sel_err
//   o_bus         DATA_W          registered bus value
//   o_bus_valid   1               bus sampled after the first unheld load
//   o_active_sel  SEL_W           currently latched select
//   o_sel_err     1               sticky illegal-select flag
module bus_src_mux_reg
  import bus_sel_pkg::*;
#(
  parameter int DATA_W      = BUS_W,
  parameter int NUM_SRC     = NUM_BUS_SRC,
  parameter int SEL_W       = SEL_CODE_W,
  parameter int NARROW_SRC  = int'(SEL_DRAM),
  parameter int NARROW_W    = 8,
  parameter int DEFAULT_SRC = int'(SEL_IRAM)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_sel_load,
  input  logic                      i_hold,
  input  logic                      i_err_clr,
  output logic [DATA_W-1:0]         o_bus,
  output logic                      o_bus_valid,
  output logic [SEL_W-1:0]          o_active_sel,
  output logic                      o_sel_err
);

  logic [SEL_W-1:0]  r_sel_q;
  logic [DATA_W-1:0] r_bus;
  logic              r_bus_valid;
  logic              r_sel_err;
  logic [SEL_W-1:0]  w_eff_sel;
  logic [DATA_W-1:0] w_src_value;
  logic              w_legal;

  // A load takes effect on the same edge. The bus therefore shows the new
  // source one cycle after the load, with no extra bubble for back-to-back loads.
  assign w_eff_sel = i_sel_load ? i_sel : r_sel_q;

  bus_src_select #(
    .DATA_W      (DATA_W),
    .NUM_SRC     (NUM_SRC),
    .SEL_W       (SEL_W),
    .NARROW_SRC  (NARROW_SRC),
    .NARROW_W    (NARROW_W),
    .DEFAULT_SRC (DEFAULT_SRC)
  ) u_src_select (
    .i_src_data (i_src_data),
    .i_sel      (w_eff_sel),
    .o_data     (w_src_value),
    .o_legal    (w_legal)
  );

  // Select latch, bus register and flags.
  // r_sel_q only ever holds a legal code, so w_legal reflects i_sel whenever
  // a load is present.
  // On the error flag, a set has priority over a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_q     <= SEL_W'(DEFAULT_SRC);
      r_bus       <= '0;
      r_bus_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      if (!i_hold) r_bus <= w_src_value;
      if (i_sel_load) r_sel_q <= w_legal ? i_sel : SEL_W'(DEFAULT_SRC);
      if (i_sel_load && !i_hold) r_bus_valid <= 1'b1;
      if (i_sel_load && !w_legal) r_sel_err <= 1'b1;
      else if (i_err_clr) r_sel_err <= 1'b0;
    end
  end

  assign o_bus        = r_bus;
  assign o_bus_valid  = r_bus_valid;
  assign o_active_sel = r_sel_q;
  assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_bus_src_mux_reg.sv
// Self-checking bench for bus_src_mux_reg.
// The stimulus process drives one directed vector per cycle on the falling
// edge. It pushes the hand-computed post-edge expectation into a queue. A
// monitor pops one entry just after each rising edge and compares it with
// the DUT outputs. Asynchronous reset behaviour is checked directly in
// mid-cycle.
module tb_bus_src_mux_reg;
  import bus_sel_pkg::*;

  typedef struct {
    logic [31:0] bus;
    logic        valid;
    logic [7:0]  act;
    logic        err;
    string       name;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [383:0]  src_data;
  logic [7:0]    sel;
  logic          sel_load;
  logic          hold;
  logic          err_clr;
  logic [31:0]   bus;
  logic          bus_valid;
  logic [7:0]    active_sel;
  logic          sel_err;

  logic [31:0]   src [12];
  exp_t          expQ[$];
  int            numVectors;
  int            numMiscompares;
  bit            done;

  bus_src_mux_reg dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_src_data   (src_data),
    .i_sel        (sel),
    .i_sel_load   (sel_load),
    .i_hold       (hold),
    .i_err_clr    (err_clr),
    .o_bus        (bus),
    .o_bus_valid  (bus_valid),
    .o_active_sel (active_sel),
    .o_sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the source array into the flat source bus.
  always_comb begin
    src_data = '0;
    for (int i = 0; i < 12; i++) src_data[i*32 +: 32] = src[i];
  end

  // Compare all four outputs against one expectation.
  task automatic checkOutput(input string name, input logic [31:0] eBus, input logic eValid,
                             input logic [7:0] eAct, input logic eErr);
    numVectors++;
    if (bus !== eBus || bus_valid !== eValid || active_sel !== eAct || sel_err !== eErr) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got bus=%h valid=%b act=%0d err=%b, want bus=%h valid=%b act=%0d err=%b",
               name, bus, bus_valid, active_sel, sel_err, eBus, eValid, eAct, eErr);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then advance to the next falling edge.
  task automatic applyStimulus(input string name, input logic load, input logic [7:0] s,
                               input logic hld, input logic clr, input logic [31:0] eBus,
                               input logic eValid, input logic [7:0] eAct, input logic eErr);
    exp_t e;
    sel_load = load;
    sel      = s;
    hold     = hld;
    err_clr  = clr;
    e.bus = eBus; e.valid = eValid; e.act = eAct; e.err = eErr; e.name = name;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one pop per rising edge whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.name, e.bus, e.valid, e.act, e.err);
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    if (!done) begin
      $display("[TB] FAIL watchdog: got timeout, want completion");
      numMiscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
    end
  end

  initial begin
    numVectors = 0;
    numMiscompares = 0;
    done = 1'b0;
    for (int i = 0; i < 12; i++) src[i] = {4{8'(i)}};
    rst_n = 1'b0; sel = '0; sel_load = 1'b0; hold = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_initial", 32'h0, 1'b0, 8'd1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Before any load, the bus follows the default source, but the valid flag stays low.
    applyStimulus("idle_default", 0, 8'h00, 0, 0, 32'h0101_0101, 0, 8'd1, 0);

    src[10] = 32'h0000_0040;
    applyStimulus("load_10",     1, 8'd10, 0, 0, 32'h0000_0040, 1, 8'd10, 0);
    src[10] = 32'h0000_0044;
    applyStimulus("track_10",    0, 8'd0,  0, 0, 32'h0000_0044, 1, 8'd10, 0);

    src[0] = 32'hDEAD_BEA5;
    applyStimulus("narrow_0",    1, 8'd0,  0, 0, 32'h0000_00A5, 1, 8'd0, 0);

    applyStimulus("illegal_ff",  1, 8'hFF, 0, 0, 32'h0101_0101, 1, 8'd1, 1);
    applyStimulus("set_wins",    1, 8'hFF, 0, 1, 32'h0101_0101, 1, 8'd1, 1);
    applyStimulus("err_clr",     0, 8'h00, 0, 1, 32'h0101_0101, 1, 8'd1, 0);

    src[9] = 32'h0000_1234;
    applyStimulus("load_9",      1, 8'd9,  0, 0, 32'h0000_1234, 1, 8'd9, 0);
    src[5] = 32'h0000_5555;
    applyStimulus("hold_load_5", 1, 8'd5,  1, 0, 32'h0000_1234, 1, 8'd5, 0);
    src[9] = 32'h0000_9999;
    applyStimulus("hold_stay",   0, 8'd0,  1, 0, 32'h0000_1234, 1, 8'd5, 0);
    applyStimulus("hold_drop",   0, 8'd0,  0, 0, 32'h0000_5555, 1, 8'd5, 0);

    src[2] = 32'h2222_0002; src[3] = 32'h3333_0003; src[4] = 32'h4444_0004;
    applyStimulus("b2b_2",       1, 8'd2,  0, 0, 32'h2222_0002, 1, 8'd2, 0);
    applyStimulus("b2b_3",       1, 8'd3,  0, 0, 32'h3333_0003, 1, 8'd3, 0);
    applyStimulus("b2b_4",       1, 8'd4,  0, 0, 32'h4444_0004, 1, 8'd4, 0);

    src[11] = 32'hBBBB_000B;
    applyStimulus("load_11",     1, 8'd11, 0, 0, 32'hBBBB_000B, 1, 8'd11, 0);
    applyStimulus("x_sel_noload",0, 8'hxx, 0, 0, 32'hBBBB_000B, 1, 8'd11, 0);
    applyStimulus("hold_ill_12", 1, 8'd12, 1, 0, 32'hBBBB_000B, 1, 8'd1, 1);
    applyStimulus("after_ill",   0, 8'd0,  0, 0, 32'h0101_0101, 1, 8'd1, 1);

    // Reset in mid-cycle with a load pending: all state clears immediately.
    sel_load = 1'b1; sel = 8'd3;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 32'h0, 1'b0, 8'd1, 1'b0);
    @(negedge clk);
    sel_load = 1'b0;
    rst_n = 1'b1;
    applyStimulus("post_reset",  0, 8'd0,  0, 0, 32'h0101_0101, 0, 8'd1, 0);

    @(negedge clk);
    if (expQ.size() != 0) begin
      numVectors++;
      numMiscompares++;
      $display("[TB] FAIL queue_drain: got %0d pending, want 0", expQ.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
